alu: RTL and testbench

- 64-bit arithmetic/logic unit for the Y86 execute stage.
- Performs add, subtract, AND or XOR on two signed operands, selected by a 3-bit opcode.
- Result and condition flags (overflow, zero, sign) are registered: one clock of latency.
- Feeds the writeback value and the condition-code register.

---
 rtl/alu.sv | 92 +++++++++
 tb/tb_alu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// alu: 64-bit Y86 execute-stage unit (add, sub, and, xor) with overflow/zero/sign flags.
// Latency: exactly one cycle; select/p/q are sampled on every rising clk edge.
// Backpressure: none; a new operation is accepted every cycle and results are never stalled.
module alu #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       select,
  input  logic [WIDTH-1:0] p,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             ofw,
  output logic             zf,
  output logic             sf
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;

  // Shared adder: subtraction is p + ~q + 1, so only operand B and carry-in change.
  logic             is_sub;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] sum;
  logic             add_ovf;

  // Operand-B conditioning for the shared adder.
  always_comb begin
    is_sub = (select == OP_SUB);
    b_in   = is_sub ? ~q : q;
  end

  assign carry[0] = is_sub;

  // Ripple carry chain of full adders; the final carry-out is never needed.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i] = p[i] ^ b_in[i] ^ carry[i];
    if (i < WIDTH - 1) begin : g_carry
      assign carry[i+1] = (p[i] & b_in[i]) | (carry[i] & (p[i] ^ b_in[i]));
    end
  end

  // Signed overflow: both adder inputs share a sign and the sum's sign differs.
  // With b_in = ~q for subtraction this is exactly "p and q differ in sign".
  assign add_ovf = (p[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != p[WIDTH-1]);

  logic [WIDTH-1:0] r_d, r_q;
  logic             ofw_d, ofw_q;
  logic             zf_d, zf_q;
  logic             sf_d, sf_q;

  // Next-state result and flags; reserved opcodes yield a clean zero result.
  always_comb begin
    r_d   = '0;
    ofw_d = 1'b0;
    case (select)
      OP_ADD, OP_SUB: begin
        r_d   = sum;
        ofw_d = add_ovf;
      end
      OP_AND:  r_d = p & q;
      OP_XOR:  r_d = p ^ q;
      default: r_d = '0;
    endcase
    zf_d = (r_d == '0);
    sf_d = r_d[WIDTH-1];
  end

  // Output registers; async reset drops any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      ofw_q <= 1'b0;
      zf_q  <= 1'b0;
      sf_q  <= 1'b0;
    end else begin
      r_q   <= r_d;
      ofw_q <= ofw_d;
      zf_q  <= zf_d;
      sf_q  <= sf_d;
    end
  end

  assign r   = r_q;
  assign ofw = ofw_q;
  assign zf  = zf_q;
  assign sf  = sf_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed vectors for alu with a queue-based scoreboard.
// Driver pushes the hand-computed expectation when it drives an operation;
// the monitor pops and compares one cycle later, just after the capturing edge.
module tb_alu;

  localparam int W = 64;
  localparam logic [W-1:0] MAX_POS = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] MAX_NEG = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] ALL_ONE = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk;
  logic         rst_n;
  logic [2:0]   select;
  logic [W-1:0] p;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         ofw;
  logic         zf;
  logic         sf;

  alu #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .select (select),
    .p      (p),
    .q      (q),
    .r      (r),
    .ofw    (ofw),
    .zf     (zf),
    .sf     (sf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         ofw;
    logic         zf;
    logic         sf;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [W-1:0] er,
                       input logic eo, input logic ez, input logic es);
    n_total++;
    if (r === er && ofw === eo && zf === ez && sf === es) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got r=%h ofw=%b zf=%b sf=%b, expected r=%h ofw=%b zf=%b sf=%b",
               name, r, ofw, zf, sf, er, eo, ez, es);
    end
  endtask

  // Drive one operation between edges and record what must appear after the next edge.
  task automatic issue(input string name, input logic [2:0] sel,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic eo,
                       input logic ez, input logic es);
    exp_t e;
    @(negedge clk);
    select = sel;
    p      = a;
    q      = b;
    e.r = er; e.ofw = eo; e.zf = ez; e.sf = es; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: the result of each sampled operation is visible just after its edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, e.r, e.ofw, e.zf, e.sf);
    end
  end

  initial begin
    rst_n  = 1'b0;
    select = 3'd0;
    p      = 64'd123;
    q      = 64'd456;

    // Reset forces zero outputs before any clock edge.
    #3;
    check("reset_initial", '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back directed vectors, one per cycle.
    issue("add_69_96",    3'd0, 64'd69,  64'd96,  64'd165, 1'b0, 1'b0, 1'b0);
    issue("add_67_9",     3'd0, 64'd67,  64'd9,   64'd76,  1'b0, 1'b0, 1'b0);
    issue("sub_6_9",      3'd1, 64'd6,   64'd9,   64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0, 1'b1);
    issue("sub_3_23",     3'd1, 64'd3,   64'd23,  64'hFFFF_FFFF_FFFF_FFEC, 1'b0, 1'b0, 1'b1);
    issue("sub_5_5",      3'd1, 64'd5,   64'd5,   64'd0,   1'b0, 1'b1, 1'b0);
    issue("and_4_456",    3'd2, 64'd4,   64'd456, 64'd0,   1'b0, 1'b1, 1'b0);
    issue("and_34_56",    3'd2, 64'd34,  64'd56,  64'd32,  1'b0, 1'b0, 1'b0);
    issue("xor_49_4",     3'd3, 64'd49,  64'd4,   64'd53,  1'b0, 1'b0, 1'b0);
    issue("xor_11_942",   3'd3, 64'd11,  64'd942, 64'd933, 1'b0, 1'b0, 1'b0);
    issue("add_max_1",    3'd0, MAX_POS, 64'd1,   MAX_NEG, 1'b1, 1'b0, 1'b1);
    issue("sub_min_1",    3'd1, MAX_NEG, 64'd1,   MAX_POS, 1'b1, 1'b0, 1'b0);
    issue("sub_0_0",      3'd1, 64'd0,   64'd0,   64'd0,   1'b0, 1'b1, 1'b0);
    issue("sub_min_min",  3'd1, MAX_NEG, MAX_NEG, 64'd0,   1'b0, 1'b1, 1'b0);
    issue("add_m1_m1",    3'd0, ALL_ONE, ALL_ONE, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
    issue("sub_max_m1",   3'd1, MAX_POS, ALL_ONE, MAX_NEG, 1'b1, 1'b0, 1'b1);
    issue("and_signbit",  3'd2, 64'h8000_0000_0000_000F, 64'hFFFF_FFFF_FFFF_FFF0,
          MAX_NEG, 1'b0, 1'b0, 1'b1);
    issue("xor_ones",     3'd3, ALL_ONE, 64'd0,   ALL_ONE, 1'b0, 1'b0, 1'b1);
    issue("rsv_sel5",     3'd5, 64'd1234, 64'd5678, 64'd0, 1'b0, 1'b1, 1'b0);
    issue("rsv_sel7_ovf", 3'd7, MAX_POS, 64'd1,   64'd0,   1'b0, 1'b1, 1'b0);
    issue("add_after_rsv",3'd0, 64'd1,   64'd2,   64'd3,   1'b0, 1'b0, 1'b0);

    // Inputs changing between edges must not disturb the registered result.
    @(posedge clk);
    #2;
    select = 3'd1;
    p      = 64'd0;
    q      = 64'd1;
    #2;
    check("hold_between_edges", 64'd3, 1'b0, 1'b0, 1'b0);

    // Load a nonzero result, then assert reset mid-cycle.
    @(negedge clk);
    select = 3'd0;
    p      = 64'd100;
    q      = 64'd200;
    @(posedge clk);
    #2;
    check("pre_reset_value", 64'd300, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    select = 3'd1;
    p      = 64'd0;
    q      = MAX_POS;
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_async_mid", '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("reset_held_edge", '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    p = 64'd10;
    q = 64'd20;
    select = 3'd0;
    begin
      exp_t e;
      e.r = 64'd30; e.ofw = 1'b0; e.zf = 1'b0; e.sf = 1'b0; e.name = "first_after_reset";
      exp_q.push_back(e);
    end
    issue("sub_after_reset", 3'd1, 64'd3, 64'd23, 64'hFFFF_FFFF_FFFF_FFEC, 1'b0, 1'b0, 1'b1);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain_timeout: %0d expectations still pending, expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
